// File: rtl/pack_matrix_collector_pkg.sv
// Shared defaults, matrix typedefs and slot-decode helpers for the matrix collector.
// Element k of a matrix lands in row k/LANES, lane k%LANES.
package pack_matrix_pkg;

  localparam int W     = 3;
  localparam int LANES = 4;
  localparam int ROWS  = 2;

  typedef logic [W-1:0]                       elem_t;
  typedef logic [LANES-1:0][W-1:0]            row_t;
  typedef logic [0:ROWS-1][LANES-1:0][W-1:0]  mat_t;

  function automatic int slot_row(input int k, input int lanes = LANES);
    return k / lanes;
  endfunction

  function automatic int slot_lane(input int k, input int lanes = LANES);
    return k % lanes;
  endfunction

endpackage

// File: rtl/pack_matrix_collector_if.sv
// Element-in / matrix-out handshake bundle; master drives elements and out_ready,
// slave is the collector.
interface pack_matrix_if #(
  parameter int W     = pack_matrix_pkg::W,
  parameter int LANES = pack_matrix_pkg::LANES,
  parameter int ROWS  = pack_matrix_pkg::ROWS
);
  localparam int N  = ROWS * LANES;
  localparam int CW = $clog2(N + 1);

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic           in_last;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_data;
  logic [CW-1:0]  out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );

endinterface

// File: rtl/pack_matrix_collector_fill_ctr.sv
// Fill counter for the matrix collector: tracks the next slot index and flags the
// accept that completes a matrix (last slot or in_last).
module pack_matrix_fill_ctr
  import pack_matrix_pkg::*;
#(
  parameter int LANES = pack_matrix_pkg::LANES,
  parameter int ROWS  = pack_matrix_pkg::ROWS,
  localparam int N    = ROWS * LANES,
  localparam int KW   = (N > 1) ? $clog2(N) : 1,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          accept,
  input  logic          last,
  output logic [KW-1:0] fill,
  output logic [RW-1:0] row,
  output logic [LW-1:0] lane,
  output logic          complete
);

  logic [KW-1:0] fill_reg;
  logic [KW-1:0] fill_next;

  assign complete = accept && (last || fill_reg == KW'(N - 1));
  assign fill     = fill_reg;
  assign row      = RW'(slot_row(int'(fill_reg), LANES));
  assign lane     = LW'(slot_lane(int'(fill_reg), LANES));

  always_comb begin
    fill_next = fill_reg;
    if (complete) begin
      fill_next = '0;
    end else if (accept) begin
      fill_next = fill_reg + KW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_reg <= '0;
    end else begin
      fill_reg <= fill_next;
    end
  end

endmodule

// File: rtl/pack_matrix_collector.sv
// Packs W-bit elements into a [0:ROWS-1][LANES-1:0][W-1:0] matrix with a registered
// output and a one-deep park slot so input keeps flowing one element per cycle.
module pack_matrix_collector
  import pack_matrix_pkg::*;
#(
  parameter int W     = pack_matrix_pkg::W,
  parameter int LANES = pack_matrix_pkg::LANES,
  parameter int ROWS  = pack_matrix_pkg::ROWS
) (
  input logic            clk,
  input logic            rst_n,
  pack_matrix_if.slave   bus
);

  localparam int N  = ROWS * LANES;
  localparam int MW = N * W;
  localparam int CW = $clog2(N + 1);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic          accept;
  logic          complete;
  logic [KW-1:0] fill;
  logic [RW-1:0] row;
  logic [LW-1:0] lane;
  logic [CW-1:0] count_new;
  logic [MW-1:0] merged;
  logic          out_free;

  logic [MW-1:0] asm_reg,        asm_next;
  logic          park_reg,       park_next;
  logic [MW-1:0] park_data_reg,  park_data_next;
  logic [CW-1:0] park_count_reg, park_count_next;
  logic          out_valid_reg,  out_valid_next;
  logic [MW-1:0] out_data_reg,   out_data_next;
  logic [CW-1:0] out_count_reg,  out_count_next;

  // in_ready is pure register state so out_ready never reaches it combinationally
  assign bus.in_ready  = !park_reg;
  assign accept        = bus.in_valid && !park_reg;
  assign out_free      = !out_valid_reg || bus.out_ready;
  assign count_new     = CW'(fill) + CW'(1);
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_count = out_count_reg;

  pack_matrix_fill_ctr #(
    .LANES (LANES),
    .ROWS  (ROWS)
  ) u_fill_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .accept   (accept),
    .last     (bus.in_last),
    .fill     (fill),
    .row      (row),
    .lane     (lane),
    .complete (complete)
  );

  // Row 0 sits at the top of the word, lane 0 at the bottom of each row
  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    localparam int R   = slot_row(gi, LANES);
    localparam int L   = slot_lane(gi, LANES);
    localparam int OFF = ((ROWS - 1 - R) * LANES + L) * W;
    assign merged[OFF +: W] = (accept && row == RW'(R) && lane == LW'(L))
                              ? bus.in_data : asm_reg[OFF +: W];
  end

  always_comb begin
    asm_next        = asm_reg;
    park_next       = park_reg;
    park_data_next  = park_data_reg;
    park_count_next = park_count_reg;
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;
    out_count_next  = out_count_reg;

    if (out_valid_reg && bus.out_ready) begin
      out_valid_next = 1'b0;
    end

    if (park_reg) begin
      if (bus.out_ready) begin
        out_valid_next = 1'b1;
        out_data_next  = park_data_reg;
        out_count_next = park_count_reg;
        park_next      = 1'b0;
      end
    end else if (complete) begin
      asm_next = '0;
      if (out_free) begin
        out_valid_next = 1'b1;
        out_data_next  = merged;
        out_count_next = count_new;
      end else begin
        park_next       = 1'b1;
        park_data_next  = merged;
        park_count_next = count_new;
      end
    end else if (accept) begin
      asm_next = merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_reg        <= '0;
      park_reg       <= 1'b0;
      park_data_reg  <= '0;
      park_count_reg <= '0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_count_reg  <= '0;
    end else begin
      asm_reg        <= asm_next;
      park_reg       <= park_next;
      park_data_reg  <= park_data_next;
      park_count_reg <= park_count_next;
      out_valid_reg  <= out_valid_next;
      out_data_reg   <= out_data_next;
      out_count_reg  <= out_count_next;
    end
  end

endmodule

// File: tb/tb_pack_matrix_collector.sv
// Directed bench for pack_matrix_collector with hand-computed matrix words.
module tb_pack_matrix_collector;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pack_matrix_if #(.W(3), .LANES(4), .ROWS(2)) bus ();

  pack_matrix_collector #(.W(3), .LANES(4), .ROWS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready)
      $display("[%0t] matrix out data=%h count=%0d", $time, bus.out_data, bus.out_count);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] d, input logic l);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 1'b0);
    bus.out_ready = 1'b0;
    step();
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (bus.out_data !== 24'h0) begin errors++; $display("FAIL reset_data: got %h expected 000000", bus.out_data); end
    checks++;
    if (bus.out_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.out_count); end
    #2 rst_n = 1'b1;
    step();
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_full_matrix();
    logic [2:0] v [8] = '{3'b001, 3'b011, 3'b100, 3'b010, 3'b110, 3'b100, 3'b010, 3'b101};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, v[i], 1'b0);
      step();
      checks++;
      if (bus.out_valid !== (i == 7)) begin errors++; $display("FAIL full_valid[%0d]: got %b expected %b", i, bus.out_valid, (i == 7)); end
    end
    checks++;
    if (bus.out_data !== 24'h519AA6) begin errors++; $display("FAIL full_data: got %h expected 519aa6", bus.out_data); end
    checks++;
    if (bus.out_count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d expected 8", bus.out_count); end
    drive(1'b0, 3'd0, 1'b0);
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_pulse_end: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_partial();
    logic [2:0] v [3] = '{3'b111, 3'b000, 3'b101};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, v[i], (i == 2));
      step();
      checks++;
      if (bus.out_valid !== (i == 2)) begin errors++; $display("FAIL partial_valid[%0d]: got %b expected %b", i, bus.out_valid, (i == 2)); end
    end
    checks++;
    if (bus.out_data !== 24'h147000) begin errors++; $display("FAIL partial_data: got %h expected 147000", bus.out_data); end
    checks++;
    if (bus.out_count !== 4'd3) begin errors++; $display("FAIL partial_count: got %0d expected 3", bus.out_count); end
    // single-element flush must land in slot 0 with everything else zero
    drive(1'b1, 3'b101, 1'b1);
    step();
    checks++;
    if (bus.out_data !== 24'h005000) begin errors++; $display("FAIL partial_restart_data: got %h expected 005000", bus.out_data); end
    checks++;
    if (bus.out_count !== 4'd1) begin errors++; $display("FAIL partial_restart_count: got %0d expected 1", bus.out_count); end
    drive(1'b0, 3'd0, 1'b0);
    step();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 1", i, bus.in_ready); end
      drive(1'b1, (i < 8) ? 3'(i) : 3'(15 - i), 1'b0);
      step();
      if (i == 7) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 24'h688FAC)
          begin errors++; $display("FAIL bp_first: got valid=%b data=%h expected valid=1 data=688fac", bus.out_valid, bus.out_data); end
      end
    end
    drive(1'b0, 3'd0, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_parked: got in_ready=%b expected 0", bus.in_ready); end
    checks++;
    if (bus.out_data !== 24'h688FAC) begin errors++; $display("FAIL bp_hold_first: got %h expected 688fac", bus.out_data); end
    step();
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_park_hold: got in_ready=%b expected 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_no_bubble: got %b expected 1", bus.out_valid); end
    checks++;
    if (bus.out_data !== 24'h977053) begin errors++; $display("FAIL bp_second_data: got %h expected 977053", bus.out_data); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_unpark: got in_ready=%b expected 1", bus.in_ready); end
  endtask

  task automatic test_stability();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 24'h977053 || bus.out_count !== 4'd8)
        begin errors++; $display("FAIL stable[%0d]: got valid=%b data=%h count=%0d expected 1/977053/8", c, bus.out_valid, bus.out_data, bus.out_count); end
    end
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stable_drain: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 3'(i % 8), 1'b0);
      step();
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, bus.in_ready); end
      checks++;
      if (bus.out_valid !== ((i % 8) == 7)) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected %b", i, bus.out_valid, ((i % 8) == 7)); end
      if ((i % 8) == 7) begin
        checks++;
        if (bus.out_data !== 24'h688FAC || bus.out_count !== 4'd8)
          begin errors++; $display("FAIL stream_matrix[%0d]: got data=%h count=%0d expected 688fac/8", i / 8, bus.out_data, bus.out_count); end
      end
    end
    drive(1'b0, 3'd0, 1'b0);
    step();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, (i < 8) ? 3'(i) : 3'd7, 1'b0);
      step();
    end
    drive(1'b0, 3'd0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b expected 1", bus.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 24'h0 || bus.out_count !== 4'd0)
      begin errors++; $display("FAIL rstmid_async: got valid=%b data=%h count=%0d expected 0/000000/0", bus.out_valid, bus.out_data, bus.out_count); end
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(7 - i), 1'b0);
      step();
      checks++;
      if (bus.out_valid !== (i == 7)) begin errors++; $display("FAIL rstmid_valid[%0d]: got %b expected %b", i, bus.out_valid, (i == 7)); end
    end
    checks++;
    if (bus.out_data !== 24'h977053 || bus.out_count !== 4'd8)
      begin errors++; $display("FAIL rstmid_clean: got data=%h count=%0d expected 977053/8", bus.out_data, bus.out_count); end
    drive(1'b0, 3'd0, 1'b0);
    step();
  endtask

  initial begin
    test_reset();
    test_full_matrix();
    test_partial();
    test_backpressure();
    test_stability();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pack_matrix_collector.md
Name: pack_matrix_collector

Overview:
Collects a stream of small W-bit elements, one per handshake, into a packed 3-D matrix word laid out as [0:ROWS-1][LANES-1:0][W-1:0]. It is the stage directly upstream of the row/lane slice-copy logic, and it produces the fully packed matrix that logic consumes. Flow control is valid/ready on both sides. A one-deep park buffer sustains one element per cycle while the output is stalled.

Parameters:
W, 3, element width in bits
LANES, 4, elements per row; lane 0 is least significant within a row
ROWS, 2, rows per matrix; row 0 is most significant in out_data
CW, $clog2(ROWS*LANES+1), width of out_count (derived; not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  element offered
in_ready  out  1  element accepted when in_valid && in_ready
in_data  in  W  element value
in_last  in  1  flush the matrix after this element (partial matrix)
out_valid  out  1  matrix available
out_ready  in  1  downstream accepts the matrix
out_data  out  ROWS*LANES*W  packed matrix [0:ROWS-1][LANES-1:0][W-1:0]
out_count  out  CW  number of valid elements in out_data, 1..ROWS*LANES

Behaviour:
- Slot mapping: the k-th accepted element of a matrix (k from 0) goes to row k/LANES, lane k%LANES. Its bit offset is ((ROWS-1-row)*LANES+lane)*W.
- Fill counter runs 0..ROWS*LANES-1. On a completing accept (k==ROWS*LANES-1 or in_last), the counter returns to 0.
- Slots not written in a partial (in_last) matrix are zero. The assembly buffer clears on every hand-off.
- Output register: holds out_data and out_count while out_valid && !out_ready. Contents stay stable under backpressure.
- Completing accept at cycle t, output free or draining (!out_valid || out_ready): the merged matrix, including the element from cycle t, loads straight into the output. out_valid is high at t+1. Latency is 1 cycle.
- Completing accept while output is full and not draining: the matrix moves to the park state. in_ready goes low the next cycle.
- Park to output: happens on the first cycle with out_ready high, in the same edge as the consume. out_valid stays high with no bubble, and in_ready returns high the cycle after.
- in_ready = !parked. It is registered state only; there is no combinational path from out_ready to in_ready.
- Non-completing accept: write the slot and increment the counter. This never depends on output state.
- in_last on the element at k==ROWS*LANES-1: a normal full matrix, out_count=ROWS*LANES.
- in_valid low mid-matrix: the partial matrix is held indefinitely. There is no timeout.
- Sustained throughput: one element per cycle, one matrix every ROWS*LANES cycles, when out_ready is held high.
- Reset (any time, asynchronous): out_valid=0, out_data=0, out_count=0, counter=0, park cleared, in_ready=1 after deassertion. Any partial or parked matrix is discarded.
- in_data and in_last are ignored unless in_valid && in_ready.

Decomposition:
- Package pack_matrix_pkg:
  - Default localparams W/LANES/ROWS.
  - Typedefs elem_t = logic [W-1:0], row_t = logic [LANES-1:0][W-1:0], mat_t = logic [0:ROWS-1][LANES-1:0][W-1:0].
  - Function slot_row/slot_lane(k).
- Sub-module pack_matrix_fill_ctr: the fill counter with completion and row/lane decode outputs. The top level holds the assembly buffer, the park flag and the output register.

Test Plan:
- Full matrix: out_ready=1; feed 001,011,100,010,110,100,010,101 on consecutive cycles, no in_last → one out_valid pulse the cycle after the 8th accept, out_data=24'h519AA6, out_count=8.
- Partial flush: feed 111,000,101 with in_last on the third → out_data=24'h147000, out_count=3. The next matrix starts at slot 0.
- Backpressure/park: out_ready=0; feed 16 elements back-to-back.
  - First matrix appears in the output.
  - Second matrix parks; in_ready drops the cycle after the 16th accept.
  - Raise out_ready for one cycle → out_valid stays high, out_data switches to the second matrix, in_ready high the next cycle.
- Streaming: out_ready=1; feed 32 elements continuously with in_valid held high → in_ready never drops, 4 matrices, out_valid pulses 8 cycles apart, each with out_count=8.
- Reset mid-operation: accept 5 elements, assert rst_n=0 asynchronously between edges → out_valid/out_data/out_count go to 0 immediately. After release, 8 new elements give a clean matrix with no leftover slots.
- Stability: hold out_ready=0 for 10 cycles with out_valid high → out_data and out_count unchanged every cycle.
